axis_greyscale_pipe: RTL

- Parametrised, pipelined RGB-to-luma converter with AXI4-Stream slave and master ports.
- Sits in the video processing chain between a packed-RGB pixel source (e.g. RGB565 from the capture path) and downstream single-channel stages such as thresholding or edge detection.
- Supports configurable channel widths and output width, and a per-pixel runtime coefficient mode: shift-add approximation or BT.601 multiply.
- Side-band tuser (start of frame) and tlast (end of line) are carried through with the pixel.

---
 rtl/axis_greyscale_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/axis_greyscale_pipe.sv
// axis_greyscale_pipe
// Three-stage AXI4-Stream RGB-to-luma converter. Stage 1 expands each
// channel to OUT_W bits, stage 2 forms weighted partial sums (shift-add
// approximation or BT.601 integer multiply, chosen per pixel), and stage 3
// adds, rounds and saturates the result. The pipeline advances as a whole
// whenever the output register is empty or being drained.
module axis_greyscale_pipe #(
  parameter  int R_W   = 5,
  parameter  int G_W   = 6,
  parameter  int B_W   = 5,
  parameter  int OUT_W = 8,
  localparam int IN_W  = R_W + G_W + B_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mode,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast
);

  // Partial sums are OUT_W+9 bits wide; the final adder gets two more bits
  // of headroom so the rounding constant can never wrap the sum.
  localparam int SW = OUT_W + 9;
  localparam int YW = SW + 2;

  logic             ce;

  logic [R_W-1:0]   r_in;
  logic [G_W-1:0]   g_in;
  logic [B_W-1:0]   b_in;
  logic [2*R_W-1:0] r_dbl;
  logic [2*G_W-1:0] g_dbl;
  logic [2*B_W-1:0] b_dbl;
  logic [OUT_W-1:0] n_r_in;
  logic [OUT_W-1:0] n_g_in;
  logic [OUT_W-1:0] n_b_in;

  logic             v1;
  logic             mode1;
  logic             user1;
  logic             last1;
  logic [OUT_W-1:0] n_r1;
  logic [OUT_W-1:0] n_g1;
  logic [OUT_W-1:0] n_b1;

  logic [SW-1:0]    a_nxt;
  logic [SW-1:0]    b_nxt;
  logic [SW-1:0]    c_nxt;

  logic             v2;
  logic             mode2;
  logic             user2;
  logic             last2;
  logic [SW-1:0]    a2;
  logic [SW-1:0]    b2;
  logic [SW-1:0]    c2;

  logic [YW-1:0]    sum;
  logic [YW-1:0]    y_full;
  logic [OUT_W-1:0] y_sat;

  logic             v3;

  // The whole pipe moves when the output slot is empty or being accepted.
  assign ce            = ~v3 | m_axis_tready;
  assign s_axis_tready = ce;
  assign m_axis_tvalid = v3;

  // Unpack {R,G,B} and widen each channel by repeating its own MSBs. Taking
  // the top OUT_W bits of {c,c} is the same as {c, c[W-1 -: OUT_W-W]} and
  // degenerates cleanly to c when the channel is already OUT_W wide.
  assign r_in   = s_axis_tdata[IN_W-1 -: R_W];
  assign g_in   = s_axis_tdata[G_W+B_W-1 -: G_W];
  assign b_in   = s_axis_tdata[B_W-1:0];
  assign r_dbl  = {r_in, r_in};
  assign g_dbl  = {g_in, g_in};
  assign b_dbl  = {b_in, b_in};
  assign n_r_in = r_dbl[2*R_W-1 -: OUT_W];
  assign n_g_in = g_dbl[2*G_W-1 -: OUT_W];
  assign n_b_in = b_dbl[2*B_W-1 -: OUT_W];

  // Stage 1: capture the normalised pixel together with its mode and side-band.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1    <= 1'b0;
      mode1 <= 1'b0;
      user1 <= 1'b0;
      last1 <= 1'b0;
      n_r1  <= '0;
      n_g1  <= '0;
      n_b1  <= '0;
    end else if (ce) begin
      v1    <= s_axis_tvalid;
      mode1 <= i_mode;
      user1 <= s_axis_tuser;
      last1 <= s_axis_tlast;
      n_r1  <= n_r_in;
      n_g1  <= n_g_in;
      n_b1  <= n_b_in;
    end
  end

  // Weighted channel terms: shift-add approximation of 0.297/0.594/0.125, or
  // BT.601 weights scaled by 256 for the multiply mode.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    c_nxt = '0;
    if (mode1) begin
      a_nxt = SW'(n_r1) * SW'(77);
      b_nxt = SW'(n_g1) * SW'(150);
      c_nxt = SW'(n_b1) * SW'(29);
    end else begin
      a_nxt = SW'(n_r1 >> 2) + SW'(n_r1 >> 5) + SW'(n_r1 >> 6);
      b_nxt = SW'(n_g1 >> 1) + SW'(n_g1 >> 4) + SW'(n_g1 >> 5);
      c_nxt = SW'(n_b1 >> 3);
    end
  end

  // Stage 2: register the partial sums.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v2    <= 1'b0;
      mode2 <= 1'b0;
      user2 <= 1'b0;
      last2 <= 1'b0;
      a2    <= '0;
      b2    <= '0;
      c2    <= '0;
    end else if (ce) begin
      v2    <= v1;
      mode2 <= mode1;
      user2 <= user1;
      last2 <= last1;
      a2    <= a_nxt;
      b2    <= b_nxt;
      c2    <= c_nxt;
    end
  end

  // Final sum; multiply mode rounds to nearest before dropping the x256
  // scale, and anything above the output range clips to full scale.
  always_comb begin
    sum    = YW'(a2) + YW'(b2) + YW'(c2) + (mode2 ? YW'(128) : YW'(0));
    y_full = mode2 ? (sum >> 8) : sum;
    y_sat  = {OUT_W{1'b1}};
    if (y_full[YW-1:OUT_W] == '0) begin
      y_sat = y_full[OUT_W-1:0];
    end
  end

  // Stage 3: the output register, held while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v3           <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tuser <= 1'b0;
      m_axis_tlast <= 1'b0;
    end else if (ce) begin
      v3           <= v2;
      m_axis_tdata <= y_sat;
      m_axis_tuser <= user2;
      m_axis_tlast <= last2;
    end
  end

endmodule
